// File: rtl/vector_mem_responder.sv
// Round-robin memory responder: grants one unit at a time, performs LOAD/STORE/MATRD
// against internal vector storage and a parameter-initialised matrix, and pulses done.
module vector_mem_responder #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 16,
    parameter int VEC_LEN   = 16,
    parameter int DEPTH     = 16,
    parameter int LAT       = 2,
    parameter logic [256*DATA_W-1:0] MAT_INIT = '0,
    localparam int VW    = VEC_LEN * DATA_W,
    localparam int UID_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_UNITS-1:0]   mem_request,
    input  logic [NUM_UNITS*4-1:0] mem_op_type,
    input  logic [NUM_UNITS*4-1:0] vec_index,
    input  logic [NUM_UNITS*4-1:0] mat_row,
    input  logic [NUM_UNITS*4-1:0] mat_col,
    input  logic [NUM_UNITS*VW-1:0] write_data,
    output logic [NUM_UNITS-1:0]   mem_grant,
    output logic [NUM_UNITS-1:0]   mem_done,
    output logic [VW-1:0]          read_data,
    output logic                   op_err,
    output logic                   resource_available,
    output logic [1:0]             dbg_state_o
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_MATRD = 4'b0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [UID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_UNITS-1:0]   armed_q, armed_d;
    logic [UID_W-1:0]       win_q;
    logic [3:0]             op_q, idx_q, row_q, col_q;
    logic [VW-1:0]          wdata_q;
    logic [NUM_UNITS-1:0]   grant_q, grant_d, done_q, done_d;
    logic                   err_q, err_d;
    logic [VW-1:0]          rdata_q, rdata_d;

    logic [VW-1:0]          vec_mem [DEPTH];
    logic [DATA_W-1:0]      mat_mem [16][16];

    logic [NUM_UNITS-1:0]   eligible;
    logic                   arb_found;
    logic [UID_W-1:0]       arb_win;
    logic                   latch_req;
    logic                   last_access;
    logic                   op_legal;
    logic                   do_commit;

    for (genvar r = 0; r < 16; r++) begin : g_mat_row
        for (genvar c = 0; c < 16; c++) begin : g_mat_col
            assign mat_mem[r][c] = MAT_INIT[(r*16+c)*DATA_W +: DATA_W];
        end
    end

    // Search starts at rr_ptr so the most recently served unit gets lowest priority.
    always_comb begin
        logic [UID_W-1:0] cand;
        cand      = '0;
        eligible  = mem_request & armed_q;
        arb_found = 1'b0;
        arb_win   = rr_ptr_q;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = UID_W'((int'(rr_ptr_q) + k) % NUM_UNITS);
            if (!arb_found && eligible[cand]) begin
                arb_found = 1'b1;
                arb_win   = cand;
            end
        end
    end

    assign last_access = (state_q == ACCESS) && (cnt_q == CNT_W'(LAT - 1));
    assign op_legal    = (op_q == OP_LOAD) || (op_q == OP_STORE) || (op_q == OP_MATRD);
    assign do_commit   = last_access && (op_q == OP_STORE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = '0;
        done_d    = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        latch_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d          = ACCESS;
                    cnt_d            = '0;
                    grant_d[arb_win] = 1'b1;
                    latch_req        = 1'b1;
                end
            end
            ACCESS: begin
                if (last_access) begin
                    state_d        = DONE;
                    done_d[win_q]  = 1'b1;
                    err_d          = !op_legal;
                    rdata_d        = '0;
                    if (op_q == OP_LOAD) begin
                        rdata_d = vec_mem[idx_q];
                    end else if (op_q == OP_STORE) begin
                        rdata_d = wdata_q;
                    end else if (op_q == OP_MATRD) begin
                        rdata_d[DATA_W-1:0] = mat_mem[row_q][col_q];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (win_q == UID_W'(NUM_UNITS - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A unit is re-armed only after it lowers its request, so a held request is served once.
    always_comb begin
        armed_d = armed_q;
        if (state_q == DONE) begin
            armed_d[win_q] = 1'b0;
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (!mem_request[u]) begin
                armed_d[u] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            armed_q  <= '1;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            win_q    <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            armed_q  <= armed_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            if (latch_req) begin
                win_q   <= arb_win;
                op_q    <= mem_op_type[int'(arb_win)*4 +: 4];
                idx_q   <= vec_index[int'(arb_win)*4 +: 4];
                row_q   <= mat_row[int'(arb_win)*4 +: 4];
                col_q   <= mat_col[int'(arb_win)*4 +: 4];
                wdata_q <= write_data[int'(arb_win)*VW +: VW];
            end
        end
    end

    // Storage is not reset; an aborted store never reaches its commit edge.
    always_ff @(posedge clk) begin
        if (do_commit) begin
            vec_mem[idx_q] <= wdata_q;
        end
    end

    assign mem_grant          = grant_q;
    assign mem_done           = done_q;
    assign op_err             = err_q;
    assign read_data          = rdata_q;
    assign resource_available = (state_q == IDLE);
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_vector_mem_responder.sv
// Directed bench for vector_mem_responder: scoreboard queues filled by the driver,
// drained by grant/done monitors sampling on the falling edge.
module tb_vector_mem_responder;

    localparam int NU    = 4;
    localparam int DW    = 16;
    localparam int VL    = 16;
    localparam int LAT   = 2;
    localparam int VW    = VL * DW;
    localparam int EW    = 2 + 1 + VW;
    localparam int CW    = EW;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_MATRD = 4'b0100;
    localparam logic [256*DW-1:0] MAT_P =
        ((256*DW)'(16'h1234) << ((4*16+9)*DW)) | ((256*DW)'(16'hBEEF) << ((9*16+4)*DW));

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NU-1:0]     mem_request = '0;
    logic [NU*4-1:0]   mem_op_type = '0;
    logic [NU*4-1:0]   vec_index = '0;
    logic [NU*4-1:0]   mat_row = '0;
    logic [NU*4-1:0]   mat_col = '0;
    logic [NU*VW-1:0]  write_data = '0;
    logic [NU-1:0]     mem_grant;
    logic [NU-1:0]     mem_done;
    logic [VW-1:0]     read_data;
    logic              op_err;
    logic              resource_available;
    logic [1:0]        dbg_state_o;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [1:0]    exp_grant_q[$];

    vector_mem_responder #(
        .NUM_UNITS(NU), .DATA_W(DW), .VEC_LEN(VL), .DEPTH(16), .LAT(LAT), .MAT_INIT(MAT_P)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_request(mem_request), .mem_op_type(mem_op_type), .vec_index(vec_index),
        .mat_row(mat_row), .mat_col(mat_col), .write_data(write_data),
        .mem_grant(mem_grant), .mem_done(mem_done), .read_data(read_data),
        .op_err(op_err), .resource_available(resource_available), .dbg_state_o(dbg_state_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
        return {VL{v}};
    endfunction

    function automatic logic [VW-1:0] ramp_pat();
        logic [VW-1:0] p;
        for (int i = 0; i < VL; i++) p[i*DW +: DW] = DW'(16 - i);
        return p;
    endfunction

    // driver tasks
    task automatic set_unit(input int u, input logic [3:0] op, input logic [3:0] idx,
                            input logic [3:0] row, input logic [3:0] col, input logic [VW-1:0] wd);
        mem_op_type[u*4 +: 4] = op;
        vec_index[u*4 +: 4]   = idx;
        mat_row[u*4 +: 4]     = row;
        mat_col[u*4 +: 4]     = col;
        write_data[u*VW +: VW] = wd;
    endtask

    // Called at a falling edge with the DUT idle; checks grant/done latency.
    task automatic run_txn(input int u, input logic [VW-1:0] exp_data, input logic exp_err,
                           input logic keep);
        int t_g;
        int t_d;
        exp_grant_q.push_back(2'(u));
        exp_q.push_back({2'(u), exp_err, exp_data});
        mem_request[u] = 1'b1;
        t_g = -1;
        t_d = -1;
        for (int n = 1; n <= 40 && t_d < 0; n++) begin
            @(negedge clk);
            if (mem_grant[u] && t_g < 0) t_g = n;
            if (mem_done[u]) begin
                t_d = n;
                chk("res_avail_done", CW'(resource_available), CW'(0));
            end
        end
        if (!keep) mem_request[u] = 1'b0;
        chk("grant_latency", CW'(t_g), CW'(1));
        chk("done_latency", CW'(t_d), CW'(LAT + 1));
        @(negedge clk);
        chk("res_avail_idle", CW'(resource_available), CW'(1));
    endtask

    // grant monitor
    always @(negedge clk) begin
        if (|mem_grant) begin
            logic [1:0] gid;
            gid = '0;
            for (int u = 0; u < NU; u++) if (mem_grant[u]) gid = 2'(u);
            chk("grant_onehot", CW'($onehot(mem_grant)), CW'(1));
            if (exp_grant_q.size() == 0) begin
                chk("grant_unexpected", CW'(mem_grant), CW'(0));
            end else begin
                chk("grant_unit", CW'(gid), CW'(exp_grant_q.pop_front()));
            end
        end
    end

    // done monitor / scoreboard
    always @(negedge clk) begin
        if (|mem_done) begin
            logic [1:0] did;
            did = '0;
            for (int u = 0; u < NU; u++) if (mem_done[u]) did = 2'(u);
            chk("done_onehot", CW'($onehot(mem_done)), CW'(1));
            if (exp_q.size() == 0) begin
                chk("done_unexpected", CW'(mem_done), CW'(0));
            end else begin
                chk("done_resp", CW'({did, op_err, read_data}), CW'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int served[NU];
        logic rejoin[NU];
        int ndone;
        int held_grants;

        // reset
        repeat (2) @(negedge clk);
        chk("rst_grant", CW'(mem_grant), CW'(0));
        chk("rst_done", CW'(mem_done), CW'(0));
        chk("rst_err", CW'(op_err), CW'(0));
        chk("rst_rdata", CW'(read_data), CW'(0));
        chk("rst_avail", CW'(resource_available), CW'(1));
        chk("rst_state", CW'(dbg_state_o), CW'(0));
        rst = 1'b0;
        @(negedge clk);

        // round-robin: all four store to slots 8..11, two rounds each
        for (int u = 0; u < NU; u++) set_unit(u, OP_STORE, 4'(8 + u), 4'd0, 4'd0, fill(16'hC0D0 + 16'(u)));
        for (int r = 0; r < 2; r++)
            for (int u = 0; u < NU; u++) begin
                exp_grant_q.push_back(2'(u));
                exp_q.push_back({2'(u), 1'b0, fill(16'hC0D0 + 16'(u))});
            end
        for (int u = 0; u < NU; u++) begin
            served[u] = 0;
            rejoin[u] = 1'b0;
        end
        ndone = 0;
        mem_request = '1;
        for (int n = 0; n < 300 && ndone < 8; n++) begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                if (rejoin[u]) begin
                    rejoin[u] = 1'b0;
                    if (served[u] < 2) mem_request[u] = 1'b1;
                end
                if (mem_done[u]) begin
                    served[u]++;
                    ndone++;
                    mem_request[u] = 1'b0;
                    rejoin[u] = 1'b1;
                end
            end
        end
        chk("rr_done_count", CW'(ndone), CW'(8));
        mem_request = '0;
        repeat (2) @(negedge clk);

        // LOAD: fill slot 3, then unit 2 loads it
        set_unit(2, OP_STORE, 4'd3, 4'd0, 4'd0, ramp_pat());
        run_txn(2, ramp_pat(), 1'b0, 1'b0);
        set_unit(2, OP_LOAD, 4'd3, 4'd0, 4'd0, fill(16'h0BAD));
        run_txn(2, ramp_pat(), 1'b0, 1'b0);
        set_unit(2, OP_LOAD, 4'd9, 4'd0, 4'd0, '0);
        run_txn(2, fill(16'hC0D1), 1'b0, 1'b0);

        // STORE then LOAD of slot 7
        set_unit(0, OP_STORE, 4'd7, 4'd0, 4'd0, fill(16'hA5A5));
        run_txn(0, fill(16'hA5A5), 1'b0, 1'b0);
        set_unit(1, OP_LOAD, 4'd7, 4'd0, 4'd0, '0);

        // held request: one grant only until it drops
        run_txn(1, fill(16'hA5A5), 1'b0, 1'b1);
        held_grants = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_grant[1]) held_grants++;
        end
        chk("held_no_regrant", CW'(held_grants), CW'(0));
        mem_request[1] = 1'b0;
        @(negedge clk);
        run_txn(1, fill(16'hA5A5), 1'b0, 1'b0);

        // MATRD and illegal op
        set_unit(3, OP_MATRD, 4'd0, 4'd4, 4'd9, fill(16'hFFFF));
        run_txn(3, VW'(16'h1234), 1'b0, 1'b0);
        set_unit(3, OP_MATRD, 4'd0, 4'd9, 4'd4, '0);
        run_txn(3, VW'(16'hBEEF), 1'b0, 1'b0);
        set_unit(3, 4'b0011, 4'd7, 4'd4, 4'd9, fill(16'h5A5A));
        run_txn(3, '0, 1'b1, 1'b0);
        set_unit(3, OP_LOAD, 4'd7, 4'd0, 4'd0, '0);
        run_txn(3, fill(16'hA5A5), 1'b0, 1'b0);

        // reset in the middle of a store to slot 5
        set_unit(0, OP_STORE, 4'd5, 4'd0, 4'd0, fill(16'h5555));
        run_txn(0, fill(16'h5555), 1'b0, 1'b0);
        set_unit(0, OP_STORE, 4'd5, 4'd0, 4'd0, fill(16'hDEAD));
        exp_grant_q.push_back(2'd0);
        mem_request[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("midop_in_access", CW'(dbg_state_o), CW'(1));
        rst = 1'b1;
        #1;
        chk("midop_grant", CW'(mem_grant), CW'(0));
        chk("midop_done", CW'(mem_done), CW'(0));
        chk("midop_err", CW'(op_err), CW'(0));
        chk("midop_rdata", CW'(read_data), CW'(0));
        chk("midop_avail", CW'(resource_available), CW'(1));
        mem_request[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_unit(0, OP_LOAD, 4'd5, 4'd0, 4'd0, '0);
        run_txn(0, fill(16'h5555), 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("exp_q_drained", CW'(exp_q.size()), CW'(0));
        chk("exp_grant_q_drained", CW'(exp_grant_q.size()), CW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_mem_responder.md
# vector_mem_responder

- Memory-side responder for the compute units' memory request interface.
- Arbitrates round-robin among NUM_UNITS units, grants one at a time.
- Performs the requested vector load, vector store or matrix-element read on internal storage, returns data with a one-cycle done pulse.
- Sits between the unit array and on-chip vector/matrix storage; also drives the global-resource-available indication the units wait on.

## Interface
- NUM_UNITS, 4: number of requesting units (unit_id width 2).
- DATA_W, 16: element width, bits.
- VEC_LEN, 16: elements per vector; VW = VEC_LEN*DATA_W is the vector bus width.
- DEPTH, 16: vector slots, addressed by 4-bit vec_index.
- LAT, 2: storage access cycles, ≥1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_request  in  NUM_UNITS  per-unit level request, held until that unit's mem_done.
- mem_op_type  in  NUM_UNITS×4  per-unit op: 0001 LOAD, 0010 STORE, 0100 MATRD; anything else is illegal.
- vec_index  in  NUM_UNITS×4  per-unit vector slot.
- mat_row, mat_col  in  NUM_UNITS×4 each  per-unit matrix coordinates (MATRD only).
- write_data  in  NUM_UNITS×VW  per-unit store data.
- mem_grant  out  NUM_UNITS  one-hot, one-cycle pulse when a unit is accepted.
- mem_done  out  NUM_UNITS  one-hot, one-cycle pulse on completion.
- read_data  out  VW  shared result bus, valid in the mem_done cycle, held afterwards.
- op_err  out  1  pulses with mem_done for an illegal op.
- resource_available  out  1  high while the FSM is in IDLE.

## Operation
- FSM states:
  - IDLE → ACCESS when any armed unit requests.
  - ACCESS holds for LAT cycles (counter) → DONE.
  - DONE → IDLE unconditionally.
- Arming:
  - A per-unit armed bit is set to 1 at reset and cleared in that unit's DONE cycle.
  - It is set again on any cycle where that unit's mem_request is 0.
  - Only requests that are both armed and high are eligible, so a request held high past mem_done is never served twice.
- Arbitration:
  - rr_ptr resets to 0.
  - Search order is rr_ptr, rr_ptr+1, … mod NUM_UNITS; the first eligible unit wins.
  - In DONE, rr_ptr ← winner+1 mod NUM_UNITS.
- On the IDLE→ACCESS edge, latch winner id, op, vec_index, mat_row, mat_col and write_data. Later changes to unit inputs have no effect.
- LOAD: read_data ← vec_mem[vec_index].
- STORE:
  - vec_mem[vec_index] ← write_data, committed on the edge ending the last ACCESS cycle.
  - read_data ← the written data (echo).
- MATRD:
  - read_data lane 0 (bits DATA_W-1:0) ← mat_mem[mat_row][mat_col]; all other lanes are 0.
  - mat_mem is a 16×16 array of DATA_W elements, loaded only by backdoor/initialization in this block.
- Illegal op (not exactly one of the three codes): no storage change, read_data ← 0, op_err=1 in the DONE cycle.

## Timing
- Request from an armed unit visible in IDLE at cycle 0:
  - mem_grant[w]=1 in cycle 1 (first ACCESS cycle).
  - mem_done[w]=1, read_data valid, in cycle LAT+1.
  - IDLE again in cycle LAT+2.
  - With LAT=2: grant at 1, done at 3.
- Back-to-back: the next winner's grant comes no earlier than cycle LAT+3. Minimum period is LAT+2 cycles.
- A LOAD granted after a STORE to the same slot returns the new data.
- Simultaneous requests: exactly one grant per transaction, following the round-robin order.
- A request that drops before grant is never served. A request that drops after grant still completes.
- resource_available is 0 throughout ACCESS and DONE.
- Reset values:
  - mem_grant=0, mem_done=0, op_err=0, read_data=0, resource_available=1.
  - State IDLE, rr_ptr=0, all armed=1.
- Reset mid-transaction aborts it: no done pulse, and an uncommitted store is discarded. vec_mem and mat_mem contents are not cleared by reset.

## Test plan
- LOAD:
  - Stimulus: vec_mem[3]=0x0001…0010; unit 2 requests LOAD vec_index=3 at cycle 0.
  - Response: mem_grant=0100 at cycle 1; mem_done=0100 at cycle 3 with read_data=vec_mem[3]; op_err=0.
- STORE then LOAD:
  - Stimulus: unit 0 STOREs 0xA5A5…A5A5 to slot 7; then unit 1 LOADs slot 7.
  - Response: the STORE echoes the data with done; the LOAD returns 0xA5A5…A5A5.
- Round-robin:
  - Stimulus: all four units request at once after reset, each dropping its request the cycle after its done and re-requesting immediately.
  - Response: grant order 0,1,2,3,0,… with no unit granted twice in a row.
- Held request:
  - Stimulus: unit 1 keeps mem_request high for 20 cycles after its mem_done.
  - Response: no second grant until it deasserts for ≥1 cycle.
- MATRD and illegal op:
  - Stimulus: mat_mem[4][9]=0x1234, MATRD by unit 3; then op 0011 by unit 3.
  - Response: first returns read_data=0x1234 in lane 0, zeros elsewhere; second returns read_data=0 with op_err=1 and storage unchanged.
- Reset mid-op:
  - Stimulus: assert rst during the ACCESS of a STORE to slot 5.
  - Response: all outputs return to reset values immediately, no mem_done, slot 5 unchanged, resource_available=1.
